l2_req_ctrl: RTL and testbench

//  L2-side request controller that sits directly downstream of the L1 blocking miss FSM.

---
 rtl/l2_req_ctrl.sv | 162 ++++++++++++++++
 tb/tb_l2_req_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_ctrl.sv
// L2-side request controller: accepts fills and writebacks from the L1 miss FSM,
// services fills first (with writeback-buffer forwarding) over a req/ack memory port.
module l2_req_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_l2,
  input  logic              rw_l2,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LINE_W-1:0] wdata_in,
  output logic              stall_l2,
  output logic              done_l2,
  output logic [LINE_W-1:0] rdata_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RESP     = 3'd3,
    WR_ISSUE = 3'd4,
    WR_WAIT  = 3'd5
  } state_t;

  state_t            state;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_data;
  logic [LINE_W-1:0] line_buf;
  logic [CNT_W-1:0]  tcnt;

  logic rd_take;
  logic wr_take;
  logic req_bad;
  logic fwd_hit;

  assign rd_take  = valid_l2 & ~rw_l2 & ~rd_pend;
  assign wr_take  = valid_l2 &  rw_l2 & ~wb_valid;
  assign req_bad  = valid_l2 & ~(rd_take | wr_take);
  assign fwd_hit  = wb_valid & (wb_addr == rd_addr);
  assign stall_l2 = rd_pend | wb_valid;

  // Request capture and service FSM; an IDLE read is dispatched on its capture edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      line_buf  <= '0;
      tcnt      <= '0;
      done_l2   <= 1'b0;
      rdata_out <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      done_l2 <= 1'b0;
      if (req_bad) begin
        err <= 1'b1;
      end
      if (rd_take) begin
        rd_pend <= 1'b1;
        rd_addr <= addr_in;
      end
      if (wr_take) begin
        wb_valid <= 1'b1;
        wb_addr  <= addr_in;
        wb_data  <= wdata_in;
      end
      case (state)
        IDLE: begin
          if (rd_pend || rd_take) begin
            state <= RD_ISSUE;
          end else if (wb_valid) begin
            state <= WR_ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (fwd_hit) begin
            line_buf <= wb_data;
            state    <= RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
            tcnt     <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            line_buf <= mem_rdata;
            mem_req  <= 1'b0;
            state    <= RESP;
          end else if (tcnt == TCNT_LAST) begin
            line_buf <= '0;
            mem_req  <= 1'b0;
            err      <= 1'b1;
            state    <= RESP;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        RESP: begin
          done_l2   <= 1'b1;
          rdata_out <= line_buf;
          rd_pend   <= 1'b0;
          state     <= IDLE;
        end
        WR_ISSUE: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wb_addr;
          mem_wdata <= wb_data;
          tcnt      <= '0;
          state     <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b0;
            state    <= IDLE;
          end else if (tcnt == TCNT_LAST) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b0;
            err      <= 1'b1;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_ctrl.sv
// Scoreboard bench for l2_req_ctrl: expected memory transactions and fill responses
// are queued by the stimulus and popped by an independent monitor.
module tb_l2_req_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         valid_l2 = 1'b0;
  logic         rw_l2 = 1'b0;
  logic [31:0]  addr_in = 32'h0;
  logic [127:0] wdata_in = 128'h0;
  logic         stall_l2;
  logic         done_l2;
  logic [127:0] rdata_out;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [127:0] mem_rdata = 128'h0;
  logic         err;

  l2_req_ctrl #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .valid_l2(valid_l2), .rw_l2(rw_l2),
    .addr_in(addr_in), .wdata_in(wdata_in), .stall_l2(stall_l2), .done_l2(done_l2),
    .rdata_out(rdata_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_t;

  mem_t         exp_mem[$];
  logic [127:0] exp_done[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;

  // memory responder controls
  logic         resp_on = 1'b1;
  int           ack_delay = 3;
  logic [127:0] rd_line = 128'h0;
  int           late_req = 0;
  int           late_done = 0;
  logic         resp_prev = 1'b0;
  logic         mon_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a new request or a fill response appears
  always @(negedge clock) begin
    mem_t e;
    if (mem_req && !mon_prev) begin
      req_cyc = cyc;
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected_req", {95'h0, mem_we, mem_addr}, 128'h0);
      end else begin
        e = exp_mem.pop_front();
        chk("mem_we", {127'h0, mem_we}, {127'h0, e.we});
        chk("mem_addr", {96'h0, mem_addr}, {96'h0, e.addr});
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
    if (done_l2) begin
      done_cyc = cyc;
      done_cnt++;
      if (exp_done.size() == 0) chk("done_unexpected", rdata_out, 128'h0);
      else chk("fill_rdata", rdata_out, exp_done.pop_front());
    end
    mon_prev = mem_req;
  end

  // Memory model: acks new requests after ack_delay cycles, or injects a stray ack
  always begin
    @(negedge clock);
    if (late_req != late_done) begin
      mem_rdata = {128{1'b1}};
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
      late_done++;
    end else if (resp_on && mem_req && !resp_prev) begin
      repeat (ack_delay - 1) @(negedge clock);
      mem_rdata = rd_line;
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
    end
    resp_prev = mem_req;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [31:0] a, input logic [127:0] d, output int cap);
    @(negedge clock);
    valid_l2 = 1'b1;
    rw_l2 = rw;
    addr_in = a;
    wdata_in = d;
    @(posedge clock);
    #1;
    cap = cyc;
    valid_l2 = 1'b0;
    rw_l2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (done_cnt > prev) seen = 1'b1;
    end
    if (!seen) chk({name, "_done_timeout"}, 128'h0, 128'h1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      step();
      if (!stall_l2 && !mem_req) idle = 1'b1;
    end
    if (!idle) chk({name, "_idle_timeout"}, 128'h0, 128'h1);
  endtask

  function automatic mem_t mk(input logic we, input logic [31:0] a, input logic [127:0] d);
    mem_t m;
    m.we = we;
    m.addr = a;
    m.wdata = d;
    return m;
  endfunction

  initial begin
    int cap;
    int cap2;
    int dc;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    chk("rst_stall", {127'h0, stall_l2}, 128'h0);
    chk("rst_done", {127'h0, done_l2}, 128'h0);
    chk("rst_mem_req", {127'h0, mem_req}, 128'h0);
    chk("rst_err", {127'h0, err}, 128'h0);
    chk("rst_rdata", rdata_out, 128'h0);

    // Fill only, ack 3 cycles after req
    rd_line = {16{8'hA5}};
    ack_delay = 3;
    exp_mem.push_back(mk(1'b0, 32'h40, 128'h0));
    exp_done.push_back({16{8'hA5}});
    dc = done_cnt;
    issue(1'b0, 32'h40, 128'h0, cap);
    wait_done(dc, "fill");
    chk("fill_req_latency", 128'(req_cyc), 128'(cap + 1));
    chk("fill_done_latency", 128'(done_cyc), 128'(cap + 5));
    chk("fill_stall_at_done", {127'h0, stall_l2}, 128'h0);
    step();
    chk("fill_stall_after", {127'h0, stall_l2}, 128'h0);
    chk("fill_done_1cyc", {127'h0, done_l2}, 128'h0);
    chk("fill_rdata_held", rdata_out, {16{8'hA5}});

    // Writeback then fill on consecutive cycles: read goes to memory first
    rd_line = {16{8'h3C}};
    exp_mem.push_back(mk(1'b0, 32'h40, 128'h0));
    exp_mem.push_back(mk(1'b1, 32'h80, {16{8'h11}}));
    exp_done.push_back({16{8'h3C}});
    dc = done_cnt;
    issue(1'b1, 32'h80, {16{8'h11}}, cap);
    issue(1'b0, 32'h40, 128'h0, cap2);
    chk("wbf_stall", {127'h0, stall_l2}, 128'h1);
    wait_done(dc, "wbf");
    chk("wbf_stall_at_done", {127'h0, stall_l2}, 128'h1);
    wait_idle("wbf");
    chk("wbf_mem_drained", 128'(exp_mem.size()), 128'h0);

    // Forward hit: no memory read, write still issued
    exp_mem.push_back(mk(1'b1, 32'h40, {16{8'h22}}));
    exp_done.push_back({16{8'h22}});
    dc = done_cnt;
    issue(1'b1, 32'h40, {16{8'h22}}, cap);
    issue(1'b0, 32'h40, 128'h0, cap2);
    wait_done(dc, "fwd");
    chk("fwd_done_latency", 128'(done_cyc), 128'(cap2 + 2));
    wait_idle("fwd");
    chk("fwd_mem_drained", 128'(exp_mem.size()), 128'h0);
    chk("err_clean", {127'h0, err}, 128'h0);

    // Timeout: no ack, abort after 8 wait cycles, then a stray ack
    resp_on = 1'b0;
    exp_mem.push_back(mk(1'b0, 32'hC0, 128'h0));
    exp_done.push_back(128'h0);
    dc = done_cnt;
    issue(1'b0, 32'hC0, 128'h0, cap);
    while (cyc < cap + 8) step();
    chk("to_req_last_wait", {127'h0, mem_req}, 128'h1);
    chk("to_err_before", {127'h0, err}, 128'h0);
    step();
    chk("to_req_dropped", {127'h0, mem_req}, 128'h0);
    chk("to_err_set", {127'h0, err}, 128'h1);
    wait_done(dc, "to");
    chk("to_done_latency", 128'(done_cyc), 128'(cap + 10));
    late_req++;
    repeat (4) step();
    chk("late_ack_rdata", rdata_out, 128'h0);
    chk("late_ack_stall", {127'h0, stall_l2}, 128'h0);
    chk("late_ack_no_done", 128'(done_cnt), 128'(dc + 1));
    resp_on = 1'b1;

    // Illegal second read while first is pending
    do_reset();
    step();
    chk("ill_err_cleared", {127'h0, err}, 128'h0);
    ack_delay = 2;
    rd_line = {4{32'h0BAD_F00D}};
    exp_mem.push_back(mk(1'b0, 32'h100, 128'h0));
    exp_done.push_back({4{32'h0BAD_F00D}});
    dc = done_cnt;
    issue(1'b0, 32'h100, 128'h0, cap);
    issue(1'b0, 32'h140, 128'h0, cap2);
    chk("ill_err", {127'h0, err}, 128'h1);
    wait_done(dc, "ill");
    wait_idle("ill");
    chk("ill_one_done", 128'(done_cnt), 128'(dc + 1));

    // Reset while waiting on a read with a buffered writeback
    resp_on = 1'b0;
    exp_mem.push_back(mk(1'b0, 32'h200, 128'h0));
    dc = done_cnt;
    issue(1'b1, 32'h300, {16{8'h77}}, cap);
    issue(1'b0, 32'h200, 128'h0, cap2);
    repeat (3) step();
    chk("rstw_in_wait", {127'h0, mem_req}, 128'h1);
    do_reset();
    step();
    chk("rstw_mem_req", {127'h0, mem_req}, 128'h0);
    chk("rstw_stall", {127'h0, stall_l2}, 128'h0);
    repeat (20) step();
    chk("rstw_no_done", 128'(done_cnt), 128'(dc));
    chk("rstw_stall_later", {127'h0, stall_l2}, 128'h0);
    chk("rstw_no_req", {127'h0, mem_req}, 128'h0);

    chk("exp_mem_drained", 128'(exp_mem.size()), 128'h0);
    chk("exp_done_drained", 128'(exp_done.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
